// File: rtl/id_pipe.sv
// id_pipe: registered instruction decode stage with skid buffer and address-to-memory bubble
module id_pipe #(
  parameter int GW = 5,
  parameter int FW = 4,
  parameter int CW = 8,
  parameter int IW = 2 + 2 * GW + FW,
  parameter int REG_AH = 2,
  parameter int REG_AL = 3,
  parameter int REG_MEM = 4,
  parameter int ADDR_GAP = 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] PRG,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1:0]    INS,
  output logic [GW-1:0] G1,
  output logic [FW-1:0] FNC,
  output logic [GW-1:0] G2,
  output logic          G3,
  output logic [CW-1:0] CNS,
  output logic          aH,
  output logic          aL,
  output logic          w,
  output logic          r
);
  localparam int GAPW = $clog2(ADDR_GAP + 2);
  logic o_v, s_v, xfer, fire, load, to_skid;
  logic [IW-1:0] skid, nw;
  logic [GAPW-1:0] gap;
  logic [1:0] d_ins;
  logic [GW-1:0] d_g1, d_g2;
  assign in_ready = !s_v;
  assign xfer = in_valid & in_ready;
  assign out_valid = o_v & !((r | w) & (gap != '0));
  assign fire = out_valid & out_ready;
  assign load = !o_v | fire;
  assign to_skid = xfer & (!load | s_v);
  assign nw = s_v ? skid : PRG;
  assign d_ins = nw[IW-1 -: 2];
  assign d_g1 = nw[IW-3 -: GW];
  assign d_g2 = nw[GW-1:0];
  // OUT, SKID and gap counter; flush drops stored words but never blocks the outgoing handshake
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      o_v <= 1'b0;
      s_v <= 1'b0;
      skid <= '0;
      gap <= '0;
      INS <= '0;
      G1 <= '0;
      FNC <= '0;
      G2 <= '0;
      G3 <= 1'b0;
      CNS <= '0;
      aH <= 1'b0;
      aL <= 1'b0;
      w <= 1'b0;
      r <= 1'b0;
    end else if (flush) begin
      o_v <= 1'b0;
      s_v <= 1'b0;
      gap <= '0;
    end else begin
      if (load) o_v <= s_v | xfer;
      if (load && (s_v || xfer)) begin
        INS <= d_ins;
        G1 <= d_g1;
        FNC <= nw[IW-3-GW -: FW];
        G2 <= d_g2;
        G3 <= nw[IW-2];
        CNS <= nw[CW-1:0];
        aH <= (d_ins != 2'b11) && (d_g1 == GW'(REG_AH));
        aL <= (d_ins != 2'b11) && (d_g1 == GW'(REG_AL));
        w <= (d_ins != 2'b11) && (d_g1 == GW'(REG_MEM));
        r <= !d_ins[1] && (d_g2 == GW'(REG_MEM));
      end
      s_v <= (s_v & !load) | to_skid;
      if (to_skid) skid <= PRG;
      gap <= (fire && (aH || aL)) ? GAPW'(ADDR_GAP) : (gap != '0) ? gap - 1'b1 : gap;
    end
  end
endmodule

// File: tb/tb_id_pipe.sv
// tb_id_pipe: directed checks of decode, flags, hazard bubble, back-pressure, flush and async reset
module tb_id_pipe;
  logic CLK = 1'b0, RST = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [15:0] PRG = '0;
  logic ir[3], ov[3], g3[3], ah[3], al[3], ww[3], rr[3];
  logic [1:0] ins[3];
  logic [4:0] g1[3], g2[3];
  logic [3:0] fnc[3];
  logic [7:0] cns[3];
  int errs = 0, checks = 0;
  always #5 CLK = ~CLK;
  for (genvar g = 0; g < 3; g++) begin : gi
    id_pipe #(.ADDR_GAP(g == 2 ? 3 : g)) u (
      .CLK(CLK), .RST(RST), .flush(flush), .in_valid(in_valid), .in_ready(ir[g]),
      .PRG(PRG), .out_valid(ov[g]), .out_ready(out_ready), .INS(ins[g]), .G1(g1[g]),
      .FNC(fnc[g]), .G2(g2[g]), .G3(g3[g]), .CNS(cns[g]), .aH(ah[g]), .aL(al[g]),
      .w(ww[g]), .r(rr[g])
    );
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic do_flush();
    flush = 1'b1;
    in_valid = 1'b0;
    tick();
    flush = 1'b0;
  endtask
  logic [15:0] fw[6] = '{16'h0400, 16'h4000, 16'h0600, 16'h4000, 16'h0800, 16'h0204};
  logic [4:0] fe[6] = '{5'b11000, 5'b10000, 5'b10100, 5'b10000, 5'b10010, 5'b10001};
  initial begin
    #3;
    chk("rst_ov", 32'(ov[1]), 0);
    chk("rst_ir", 32'(ir[1]), 1);
    chk("rst_fields", 32'({ins[1], g1[1], fnc[1], g2[1], g3[1], cns[1], ah[1], al[1], ww[1], rr[1]}), 0);
    #9 RST = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    PRG = 16'hC8FF;
    tick();
    in_valid = 1'b0;
    chk("dec_ov", 32'(ov[1]), 1);
    chk("dec_ins", 32'(ins[1]), 3);
    chk("dec_g1", 32'(g1[1]), 4);
    chk("dec_fnc", 32'(fnc[1]), 7);
    chk("dec_g2", 32'(g2[1]), 31);
    chk("dec_g3", 32'(g3[1]), 1);
    chk("dec_cns", 32'(cns[1]), 8'hFF);
    chk("dec_flags", 32'({ah[1], al[1], ww[1], rr[1]}), 0);
    tick();
    chk("dec_drain", 32'(ov[1]), 0);
    for (int i = 0; i < 6; i++) begin
      PRG = fw[i];
      in_valid = 1'b1;
      tick();
      chk($sformatf("flags%0d", i), 32'({ov[1], ah[1], al[1], ww[1], rr[1]}), 32'(fe[i]));
    end
    do_flush();
    in_valid = 1'b1;
    PRG = 16'h0400;
    tick();
    chk("hz_e1_g0", 32'(ov[0]), 1);
    chk("hz_e1_g1", 32'(ov[1]), 1);
    chk("hz_e1_g3", 32'(ov[2]), 1);
    PRG = 16'h0204;
    tick();
    in_valid = 1'b0;
    chk("hz_e2_g0", 32'(ov[0]), 1);
    chk("hz_e2_g1", 32'(ov[1]), 0);
    chk("hz_e2_g3", 32'(ov[2]), 0);
    tick();
    chk("hz_e3_g1", 32'(ov[1]), 1);
    chk("hz_e3_g3", 32'(ov[2]), 0);
    tick();
    chk("hz_e4_g3", 32'(ov[2]), 0);
    tick();
    chk("hz_e5_g3", 32'(ov[2]), 1);
    chk("hz_e5_g2", 32'(g2[2]), 4);
    do_flush();
    out_ready = 1'b0;
    in_valid = 1'b1;
    PRG = 16'h4011;
    chk("bp_ir0", 32'(ir[1]), 1);
    tick();
    chk("bp_ov1", 32'({ov[1], cns[1]}), 32'h111);
    chk("bp_ir1", 32'(ir[1]), 1);
    PRG = 16'h4012;
    tick();
    chk("bp_ir2", 32'(ir[1]), 0);
    PRG = 16'h4013;
    tick();
    chk("bp_ir3", 32'(ir[1]), 0);
    chk("bp_hold", 32'(cns[1]), 8'h11);
    PRG = 16'h4014;
    tick();
    chk("bp_ir4", 32'(ir[1]), 0);
    PRG = 16'h4013;
    out_ready = 1'b1;
    tick();
    chk("bp_o2", 32'({ov[1], cns[1]}), 32'h112);
    chk("bp_ir5", 32'(ir[1]), 1);
    tick();
    in_valid = 1'b0;
    chk("bp_o3", 32'({ov[1], cns[1]}), 32'h113);
    tick();
    chk("bp_empty", 32'(ov[1]), 0);
    out_ready = 1'b0;
    in_valid = 1'b1;
    PRG = 16'h4011;
    tick();
    PRG = 16'h4012;
    tick();
    chk("fl_full", 32'(ir[1]), 0);
    flush = 1'b1;
    PRG = 16'h4013;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_ov", 32'(ov[1]), 0);
    chk("fl_ir", 32'(ir[1]), 1);
    out_ready = 1'b1;
    tick();
    chk("fl_drop", 32'(ov[1]), 0);
    out_ready = 1'b0;
    in_valid = 1'b1;
    PRG = 16'h0400;
    tick();
    PRG = 16'h0204;
    tick();
    out_ready = 1'b1;
    in_valid = 1'b0;
    tick();
    chk("flg_mask", 32'(ov[2]), 0);
    out_ready = 1'b0;
    in_valid = 1'b1;
    PRG = 16'h0600;
    tick();
    chk("flg_full", 32'(ir[2]), 0);
    flush = 1'b1;
    PRG = 16'h0800;
    tick();
    flush = 1'b0;
    chk("flg_ov", 32'(ov[2]), 0);
    chk("flg_ir", 32'(ir[2]), 1);
    PRG = 16'h0204;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("flg_nobubble", 32'({ov[2], g2[2]}), 32'h24);
    out_ready = 1'b0;
    in_valid = 1'b1;
    PRG = 16'hC8FF;
    tick();
    PRG = 16'h4011;
    tick();
    #2 RST = 1'b1;
    #1;
    chk("ar_ov", 32'(ov[1]), 0);
    chk("ar_ir", 32'(ir[1]), 1);
    chk("ar_fields", 32'({ins[1], g1[1], fnc[1], g2[1], g3[1], cns[1], ah[1], al[1], ww[1], rr[1]}), 0);
    #1 RST = 1'b0;
    PRG = 16'h4012;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("ar_lat", 32'({ov[1], cns[1]}), 32'h112);
    tick();
    chk("ar_empty", 32'(ov[1]), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/id_pipe.md
# id_pipe

Registered, parametrised instruction-decode stage for the 8-bit CPU. It accepts raw program words from fetch over a valid/ready handshake and splits them into opcode, register, function and constant fields. It flags address-register and memory accesses, and presents the decoded instruction to execute through a skid-buffered valid/ready interface. It also enforces a programmable bubble between an address-register write and a following memory access.

## Interface
- GW, 5: register-select field width (G1, G2)
- FW, 4: function field width
- CW, 8: constant width; CW ≤ FW+GW
- IW, 2+2*GW+FW: instruction width (16 at defaults)
- REG_AH, 2: register index of address-high
- REG_AL, 3: register index of address-low
- REG_MEM, 4: register index of memory data port
- ADDR_GAP, 1: bubble cycles after an address write before a memory access; 0 disables
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous pipeline flush
- in_valid  in  1  PRG valid
- in_ready  out  1  stage can accept PRG
- PRG  in  IW  instruction word
- out_valid  out  1  decoded instruction valid
- out_ready  in  1  execute accepts
- INS  out  2  PRG[IW-1:IW-2]
- G1  out  GW  destination select, PRG[IW-3 -: GW]
- FNC  out  FW  function, next FW bits below G1
- G2  out  GW  source select, PRG[GW-1:0]
- G3  out  1  PRG[IW-2]
- CNS  out  CW  PRG[CW-1:0]
- aH, aL, w  out  1 each  INS≠2'b11 and G1==REG_AH / REG_AL / REG_MEM
- r  out  1  INS[1]==0 and G2==REG_MEM

## Operation
- Storage: output register (OUT, decoded fields + valid) and one skid register (SKID, raw PRG + valid).
- in_ready = !SKID.valid, registered. A transfer occurs when in_valid & in_ready.
- OUT loads when OUT is empty or its contents are leaving (out_valid & out_ready). It loads from SKID if SKID is valid, otherwise from PRG on a transfer.
- If a transfer occurs and OUT cannot load, PRG goes into SKID.
- Decode is combinational on the word being loaded. Fields are registered, so all outputs are stable while OUT is held.
- Gap counter gap (width ≥ clog2(ADDR_GAP+1)):
  - Loaded with ADDR_GAP on a handshake of an instruction with aH|aL.
  - Otherwise decrements toward 0 each cycle; saturates at 0.
- out_valid = OUT.valid & !((r|w) & gap≠0). A masked instruction stays in OUT. Fields remain visible, but execute must ignore them while out_valid=0.
- Non-memory instructions are never delayed by gap.
- flush clears OUT.valid, SKID.valid and gap. PRG offered in the flush cycle is dropped. in_ready is 1 the next cycle.
- Order is strictly preserved; no instruction is duplicated or lost except by flush.

## Timing
- Reset values:
  - in_ready=1; out_valid=0.
  - INS, G1, FNC, G2, G3, CNS, aH, aL, r, w = 0.
  - SKID empty; gap=0.
- Latency: PRG accepted at edge N appears with out_valid=1 after edge N. That is 1 cycle, without a hazard.
- Throughput: 1 instruction/cycle with out_ready held 1.
- Back-pressure: at most 2 words are absorbed after out_ready falls. in_ready drops the cycle after SKID fills.
- Hazard: address write handshaken at edge N, memory access in OUT.
  - out_valid=0 for cycles N+1 … N+ADDR_GAP.
  - out_valid=1 from cycle N+ADDR_GAP+1.
- Simultaneous flush and handshake: the downstream handshake completes. flush wins for all stored state, including gap.
- Simultaneous OUT leaving, SKID valid and new transfer: OUT←SKID and SKID←PRG in the same edge.
- RST asserted mid-operation immediately forces the reset values, regardless of the clock.

## Test plan
- Decode: PRG=0xC8FF, out_ready=1 → next cycle INS=3, G1=4, FNC=7, G2=31, G3=1, CNS=0xFF, aH=aL=r=w=0.
- Flags: stream 0x0400, 0x0600, 0x0800, 0x0204 with no hazard (address words separated by non-memory ops) → aH, aL, w, r asserted respectively, one per cycle.
- Hazard: stream 0x0400 then 0x0204 with ADDR_GAP=1 → out_valid pattern 1,0,1. With ADDR_GAP=0 → 1,1. With ADDR_GAP=3 → 1,0,0,0,1.
- Back-pressure: out_ready=0 while 4 words are offered → exactly 2 accepted, in_ready=0 from the 3rd cycle. Raise out_ready → words emerge in order, no loss.
- Flush: flush with OUT and SKID full and gap=1 → next cycle out_valid=0, in_ready=1, gap=0. A following 0x0204 issues without a bubble.
- Async reset: assert RST between clock edges with data in flight → all outputs take their reset values immediately. First word after release has 1-cycle latency.
